wb_copy_master: RTL

//  Wishbone master that copies LEN 32-bit words from SRC to DST on one port of the dual-port wishbone RAM block.

---
 rtl/wb_copy_master.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/wb_copy_master.sv
// Wishbone word-copy master: reads LEN words from SRC and writes them to DST,
// one outstanding request at a time, with an ack timeout that aborts the copy.
module wb_copy_master #(
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [A_WIDTH:0]   src_addr_i,
    input  logic [A_WIDTH:0]   dst_addr_i,
    input  logic [A_WIDTH+1:0] len_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic               wb_stb_o,
    output logic [A_WIDTH:0]   wb_addr_o,
    output logic [3:0]         wb_we_o,
    output logic [31:0]        wb_data_o,
    input  logic               wb_ack_i,
    input  logic               wb_stall_i,
    input  logic [31:0]        wb_data_i
);

    localparam int unsigned AW = A_WIDTH + 1;
    localparam int unsigned LW = A_WIDTH + 2;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            stb_q, stb_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [3:0]      we_q, we_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            accept;
    logic            timeout_hit;

    assign accept      = stb_q && !wb_stall_i;
    // Abort on the TIMEOUT-th edge after accept that still has no ack.
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        stb_d   = stb_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        src_d   = src_addr_i;
                        dst_d   = dst_addr_i;
                        rem_d   = len_i;
                        stb_d   = 1'b1;
                        we_d    = 4'h0;
                        addr_d  = src_addr_i;
                        busy_d  = 1'b1;
                        state_d = S_RD_REQ;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FINISH;
                    end
                end
            end
            S_RD_REQ: begin
                if (accept) begin
                    stb_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (wb_ack_i) begin
                    wdata_d = wb_data_i;
                    stb_d   = 1'b1;
                    we_d    = 4'hF;
                    addr_d  = dst_q;
                    state_d = S_WR_REQ;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WR_REQ: begin
                if (accept) begin
                    stb_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (wb_ack_i) begin
                    src_d = src_q + AW'(1);
                    dst_d = dst_q + AW'(1);
                    rem_d = rem_q - LW'(1);
                    we_d  = 4'h0;
                    if (rem_q == LW'(1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FINISH;
                    end else begin
                        stb_d   = 1'b1;
                        addr_d  = src_q + AW'(1);
                        state_d = S_RD_REQ;
                    end
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign wb_stb_o  = stb_q;
    assign wb_addr_o = addr_q;
    assign wb_we_o   = we_q;
    assign wb_data_o = wdata_q;

endmodule
